// File: rtl/fetch_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch slice.
// Optional feature macro consumed by fetch_sequencer: FETCH_PERF_CNT_EN.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_e;

  localparam int         FETCH_STEP        = 4;
  localparam logic [1:0] ALIGN_MASK        = 2'b11;
  localparam int         DEFAULT_RESET_PC  = 100;
  localparam int         DEFAULT_MEM_BYTES = 16384;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, instruction memory, redirect source and decode.
// The master side is the fetch sequencer; the slave side is its environment.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_target;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_pc,
    input  redir_valid,
    input  redir_target
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_pc,
    output redir_valid,
    output redir_target
  );

endinterface

// File: rtl/fetch_perf_cnt.sv
// Saturating fetch/bubble event counters, only present when FETCH_PERF_CNT_EN is defined.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture_i,
  input  logic        bubble_i,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
);

  logic [31:0] fetched_q;
  logic [31:0] bubbles_q;

  // Count events, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      if (capture_i && (fetched_q != '1)) fetched_q <= fetched_q + 32'd1;
      if (bubble_i && (bubbles_q != '1)) bubbles_q <= bubbles_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives the instruction memory address
// and fills the IF/ID register toward decode with stall, redirect and fault handling.
// Optional feature: define FETCH_PERF_CNT_EN to add perf_fetched/perf_bubbles outputs.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int RESET_PC  = DEFAULT_RESET_PC,
  parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  fetch_sequencer_if.master bus,
  output logic [1:0]        fsm_state,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles
`endif
);

  localparam logic [ADDR_W-1:0] LAST_LEGAL = ADDR_W'(MEM_BYTES - FETCH_STEP);
  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(FETCH_STEP);

  function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
    return ((a[1:0] & ALIGN_MASK) == 2'b00) && (a <= LAST_LEGAL);
  endfunction

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              id_valid_q, id_valid_d;
  logic [31:0]       id_instr_q, id_instr_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

  logic redir_ok;
  logic pc_ok;
  logic stall;

  assign redir_ok = addr_legal(bus.redir_target);
  assign pc_ok    = addr_legal(pc_q);
  assign stall    = id_valid_q && !bus.id_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: redirects beat stalls, stalls beat the range check on the PC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.redir_valid && !redir_ok) state_d = S_FAULT;
        else if (start)                   state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.redir_valid) begin
          if (!redir_ok) state_d = S_FAULT;
        end else if (!stall && !pc_ok) begin
          state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        if (start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next PC, IF/ID register contents and fault address for the current state.
  always_comb begin
    pc_d         = pc_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    fault_addr_d = fault_addr_q;
    case (state_q)
      S_IDLE: begin
        id_valid_d = 1'b0;
        if (bus.redir_valid) begin
          if (redir_ok) pc_d = bus.redir_target;
          else          fault_addr_d = bus.redir_target;
        end
      end
      S_RUN: begin
        if (bus.redir_valid) begin
          id_valid_d = 1'b0;
          if (redir_ok) pc_d = bus.redir_target;
          else          fault_addr_d = bus.redir_target;
        end else if (!stall) begin
          if (!pc_ok) begin
            fault_addr_d = pc_q;
            id_valid_d   = 1'b0;
          end else begin
            id_instr_d = bus.imem_rdata;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
            pc_d       = pc_q + STEP;
          end
        end
      end
      S_FAULT: begin
        id_valid_d = 1'b0;
        if (start) pc_d = RESET_ADDR;
      end
      default: id_valid_d = 1'b0;
    endcase
  end

  // PC, IF/ID register and fault address storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_ADDR;
      id_valid_q   <= 1'b0;
      id_instr_q   <= '0;
      id_pc_q      <= '0;
      fault_addr_q <= '0;
    end else begin
      pc_q         <= pc_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.id_instr  = id_instr_q;
  assign bus.id_pc     = id_pc_q;
  assign fsm_state     = state_q;
  assign fault         = (state_q == S_FAULT);
  assign fault_addr    = fault_addr_q;

`ifdef FETCH_PERF_CNT_EN
  logic capture_en;
  logic bubble_en;

  assign capture_en = (state_q == S_RUN) && !bus.redir_valid && !stall && pc_ok;
  assign bubble_en  = (state_q == S_RUN) && !id_valid_q;

  fetch_perf_cnt u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .capture_i    (capture_en),
    .bubble_i     (bubble_en),
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
  );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a directed vector table, async-reset
// sequences, and randomized traffic compared against a behavioural model.
// Optional feature macro FETCH_PERF_CNT_EN also enables the counter checks.
module tb_fetch_sequencer;

  localparam int RESET_PC  = 100;
  localparam int MEM_BYTES = 16384;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  fsmState;
  logic        faultO;
  logic [31:0] faultAddr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perfFetched;
  logic [31:0] perfBubbles;
`endif

  int total = 0;
  int bad   = 0;

  fetch_sequencer_if #(.ADDR_W(32)) bus ();

  fetch_sequencer #(
    .RESET_PC  (RESET_PC),
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .fsm_state  (fsmState),
    .fault      (faultO),
    .fault_addr (faultAddr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perfFetched),
    .perf_bubbles (perfBubbles)
`endif
  );

  always #5 clk = ~clk;

  // Test image: fixed words at the directed addresses, a distinct pattern elsewhere.
  function automatic logic [31:0] imemWord(input logic [31:0] a);
    case (a)
      32'd100: return 32'h48080000;
      32'd104: return 32'h48090004;
      32'd108: return 32'h480a0008;
      32'd200: return 32'h24130005;
      default: return {a[15:0] ^ 16'hc3a5, a[15:0]};
    endcase
  endfunction

  assign bus.imem_rdata = imemWord(bus.imem_addr);

  typedef struct {
    bit          st;
    bit          rv;
    logic [31:0] rt;
    bit          rdy;
    bit          eValid;
    logic [31:0] ePc;
    logic [31:0] eInstr;
    logic [31:0] eAddr;
    logic [1:0]  eState;
    logic [31:0] eFaultAddr;
  } vec_t;

  vec_t vecs[$];

  // Behavioural reference: mode 0 idle, 1 fetching, 2 faulted.
  int          mMode;
  logic [31:0] mPc;
  bit          mValid;
  logic [31:0] mInstr;
  logic [31:0] mIdPc;
  logic [31:0] mFaultAddr;
  longint      mFetched;
  longint      mBubbles;

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a <= 32'(MEM_BYTES - 4));
  endfunction

  task automatic modelReset();
    mMode = 0; mPc = 32'(RESET_PC); mValid = 0; mInstr = 0; mIdPc = 0; mFaultAddr = 0;
    mFetched = 0; mBubbles = 0;
  endtask

  task automatic modelStep();
    bit redir;
    logic [31:0] tgt;
    redir = bus.redir_valid;
    tgt = bus.redir_target;
    if (mMode == 1 && !mValid) mBubbles++;
    if (mMode == 0) begin
      if (redir && !legal(tgt)) begin
        mMode = 2; mFaultAddr = tgt;
      end else begin
        if (redir) mPc = tgt;
        if (start) mMode = 1;
      end
    end else if (mMode == 1) begin
      if (redir) begin
        mValid = 0;
        if (legal(tgt)) mPc = tgt;
        else begin mMode = 2; mFaultAddr = tgt; end
      end else if (mValid && !bus.id_ready) begin
        mValid = mValid;
      end else if (!legal(mPc)) begin
        mMode = 2; mFaultAddr = mPc; mValid = 0;
      end else begin
        mInstr = imemWord(mPc); mIdPc = mPc; mValid = 1; mPc = mPc + 32'd4; mFetched++;
      end
    end else begin
      if (start) begin mMode = 0; mPc = 32'(RESET_PC); end
    end
  endtask

  task automatic applyStimulus(input bit st, input bit rv, input logic [31:0] rt, input bit rdy);
    start            = st;
    bus.redir_valid  = rv;
    bus.redir_target = rt;
    bus.id_ready     = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input bit eValid, input logic [31:0] ePc,
                          input logic [31:0] eInstr, input logic [31:0] eAddr,
                          input logic [1:0] eState, input logic [31:0] eFaultAddr);
    checkOutput({tag, ".id_valid"}, 32'(bus.id_valid), 32'(eValid));
    checkOutput({tag, ".id_pc"}, bus.id_pc, ePc);
    checkOutput({tag, ".id_instr"}, bus.id_instr, eInstr);
    checkOutput({tag, ".imem_addr"}, bus.imem_addr, eAddr);
    checkOutput({tag, ".fsm_state"}, 32'(fsmState), 32'(eState));
    checkOutput({tag, ".fault"}, 32'(faultO), 32'(eState == 2'd2));
    checkOutput({tag, ".fault_addr"}, faultAddr, eFaultAddr);
  endtask

  task automatic checkModel(input string tag);
    checkAll(tag, mValid, mIdPc, mInstr, mPc, 2'(mMode), mFaultAddr);
  endtask

  // Assert reset immediately, check the cleared outputs before any clock edge, then release.
  task automatic resetDut(input string tag);
    rst_n = 1'b0;
    #1;
    checkAll(tag, 1'b0, 32'd0, 32'd0, 32'(RESET_PC), 2'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic addVec(input bit st, input bit rv, input logic [31:0] rt, input bit rdy,
                        input bit ev, input logic [31:0] ep, input logic [31:0] ei,
                        input logic [31:0] ea, input logic [1:0] es, input logic [31:0] ef);
    vec_t v;
    v = '{st, rv, rt, rdy, ev, ep, ei, ea, es, ef};
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] randTarget();
    case ($urandom_range(0, 5))
      0, 1:    return 32'($urandom_range(0, (MEM_BYTES - 4) / 4)) * 32'd4;
      2:       return 32'(MEM_BYTES - 4) - 32'($urandom_range(0, 3)) * 32'd4;
      3:       return 32'($urandom_range(0, 4000)) * 32'd4 + 32'($urandom_range(1, 3));
      4:       return 32'(MEM_BYTES) + 32'($urandom_range(0, 100)) * 32'd4;
      default: return 32'hFFFFFFFC;
    endcase
  endfunction

  initial begin
    logic [31:0] wEnd;
    wEnd = imemWord(32'd16380);

    rst_n = 1'b1;
    applyStimulus(0, 0, 32'd0, 1);
    #2;
    resetDut("reset");

    //     st rv target  rdy  valid id_pc   id_instr      addr    st   fault_addr
    addVec(1, 0, 32'd0,   1,   0, 32'd0,     32'd0,        32'd100,   1, 32'd0);
    addVec(0, 0, 32'd0,   1,   1, 32'd100,   32'h48080000, 32'd104,   1, 32'd0);
    addVec(0, 0, 32'd0,   1,   1, 32'd104,   32'h48090004, 32'd108,   1, 32'd0);
    addVec(1, 0, 32'd0,   0,   1, 32'd104,   32'h48090004, 32'd108,   1, 32'd0);
    addVec(0, 0, 32'd0,   0,   1, 32'd104,   32'h48090004, 32'd108,   1, 32'd0);
    addVec(0, 0, 32'd0,   0,   1, 32'd104,   32'h48090004, 32'd108,   1, 32'd0);
    addVec(0, 0, 32'd0,   1,   1, 32'd108,   32'h480a0008, 32'd112,   1, 32'd0);
    addVec(0, 1, 32'd200, 1,   0, 32'd108,   32'h480a0008, 32'd200,   1, 32'd0);
    addVec(0, 0, 32'd0,   1,   1, 32'd200,   32'h24130005, 32'd204,   1, 32'd0);
    addVec(0, 1, 32'd100, 0,   0, 32'd200,   32'h24130005, 32'd100,   1, 32'd0);
    addVec(0, 0, 32'd0,   0,   1, 32'd100,   32'h48080000, 32'd104,   1, 32'd0);
    addVec(0, 1, 32'd202, 0,   0, 32'd100,   32'h48080000, 32'd104,   2, 32'd202);
    addVec(0, 1, 32'd300, 1,   0, 32'd100,   32'h48080000, 32'd104,   2, 32'd202);
    addVec(1, 0, 32'd0,   1,   0, 32'd100,   32'h48080000, 32'd100,   0, 32'd202);
    addVec(1, 1, 32'd16380, 1, 0, 32'd100,   32'h48080000, 32'd16380, 1, 32'd202);
    addVec(0, 0, 32'd0,   1,   1, 32'd16380, wEnd,         32'd16384, 1, 32'd202);
    addVec(0, 0, 32'd0,   1,   0, 32'd16380, wEnd,         32'd16384, 2, 32'd16384);
    addVec(1, 0, 32'd0,   1,   0, 32'd16380, wEnd,         32'd100,   0, 32'd16384);
    addVec(1, 0, 32'd0,   1,   0, 32'd16380, wEnd,         32'd100,   1, 32'd16384);
    addVec(0, 0, 32'd0,   1,   1, 32'd100,   32'h48080000, 32'd104,   1, 32'd16384);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].st, vecs[i].rv, vecs[i].rt, vecs[i].rdy);
      @(posedge clk);
      #1;
      checkAll($sformatf("vec%0d", i), vecs[i].eValid, vecs[i].ePc, vecs[i].eInstr,
               vecs[i].eAddr, vecs[i].eState, vecs[i].eFaultAddr);
    end

    // Mid-stream reset while an instruction is valid and a fault address is recorded.
    applyStimulus(0, 0, 32'd0, 1);
    resetDut("midReset");

    // Randomized traffic against the reference model, with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, randTarget(),
                    $urandom_range(0, 3) != 0);
      @(posedge clk);
      modelStep();
      #1;
      checkModel("rand");
      if (i == 1500) begin
        applyStimulus(0, 0, 32'd0, 1);
        resetDut("randReset");
      end
    end

`ifdef FETCH_PERF_CNT_EN
    checkOutput("perf_fetched", perfFetched, (mFetched > 64'hFFFFFFFF) ? 32'hFFFFFFFF : 32'(mFetched));
    checkOutput("perf_bubbles", perfBubbles, (mBubbles > 64'hFFFFFFFF) ? 32'hFFFFFFFF : 32'(mBubbles));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the pipelined core.
- Owns the PC register and drives the byte-addressed instruction memory address port; the memory read is combinational, big-endian and 4 bytes wide.
- Captures the returned word into an IF/ID output register with a valid/ready handshake toward decode.
- Handles stalls, branch/jump redirects and address faults, and sits between the instruction memory and the decode stage.

Parameters:
- RESET_PC, 100, byte address loaded into the PC at reset and on restart.
- MEM_BYTES, 16384, instruction memory size in bytes. The last legal fetch address is MEM_BYTES-4.
- ADDR_W, 32, PC and address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE and begin fetching. In FAULT, clears the fault.
- imem_addr  out  ADDR_W  address to instruction memory; always equals pc_q.
- imem_rdata  in  32  instruction word for imem_addr, valid in the same cycle.
- id_valid  out  1  IF/ID register holds a valid instruction.
- id_ready  in  1  decode accepts id_instr this cycle.
- id_instr  out  32  fetched instruction.
- id_pc  out  ADDR_W  address of id_instr.
- redir_valid  in  1  branch/jump redirect request.
- redir_target  in  ADDR_W  redirect byte address.
- fsm_state  out  2  IDLE=0, RUN=1, FAULT=2.
- fault  out  1  sticky fault flag.
- fault_addr  out  ADDR_W  offending address.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE, pc_q=RESET_PC.
  - id_valid=0, id_instr=0, id_pc=0.
  - fault=0, fault_addr=0.
- An address is illegal if addr[1:0]!=0 or addr>MEM_BYTES-4.
- IDLE:
  - id_valid held 0.
  - redir_valid with a legal target loads pc_q=target and stays in IDLE.
  - redir_valid with an illegal target goes to FAULT.
  - start goes to RUN next cycle. If start and redir_valid are both asserted, the redirect is applied first, then RUN is entered.
- RUN, priority order, evaluated each cycle:
  1. redir_valid:
     - id_valid<=0 (a handshake in the same cycle still counts as accepted).
     - Legal target: pc_q<=target. Exactly one bubble cycle follows.
     - Illegal target: FAULT with fault_addr<=target.
  2. id_valid & !id_ready: hold pc_q and all id_* outputs unchanged.
  3. Else, if pc_q is illegal: FAULT with fault_addr<=pc_q and id_valid<=0.
  4. Else capture: id_instr<=imem_rdata, id_pc<=pc_q, id_valid<=1, pc_q<=pc_q+4.
  - Throughput is one instruction per cycle when id_ready=1.
  - Latency is one cycle from pc_q to id_*.
- FAULT:
  - fault=1, id_valid=0, and pc_q is frozen.
  - redir_valid is ignored.
  - start clears fault, sets pc_q<=RESET_PC and goes to IDLE. fault_addr is retained until the next fault or reset.
- start is ignored in RUN.
- pc_q+4 wraps modulo 2^ADDR_W; a wrapped pc_q is then caught by the range check.
- rst_n asserted mid-RUN clears everything immediately, including any pending redirect effect.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds two 32-bit outputs, perf_fetched and perf_bubbles, both reset to 0:
  - perf_fetched increments on every RUN capture.
  - perf_bubbles increments on every RUN cycle with id_valid=0.
  - Both saturate at 0xFFFFFFFF.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding (IDLE/RUN/FAULT),
  - FETCH_STEP=4,
  - the alignment mask 2'b11,
  - the default RESET_PC and MEM_BYTES constants.
- Optional sub-module fetch_perf_cnt holds the saturating counters. It is instantiated only under FETCH_PERF_CNT_EN.
- The FSM, PC and IF/ID register stay in one module.

Test Plan:
- Reset then start with imem modelled on the test image, id_ready=1:
  - id_pc=100 with id_instr=0x48080000,
  - then 104 with 0x48090004,
  - then 108 with 0x480a0008, on consecutive cycles.
- Hold id_ready=0 for 3 cycles while id_pc=104: id_instr stays 0x48090004 and imem_addr stays 108. Release id_ready and 108 follows the next cycle.
- Redirect in RUN to target 200: one cycle with id_valid=0, then id_pc=200 with id_instr=0x24130005. The redirect must also win while id_ready=0.
- Redirect to 202: fsm_state=2, fault=1, fault_addr=202, id_valid=0. Then start gives IDLE with imem_addr=100.
- Redirect to 16380 with id_ready=1:
  - the word at 16380 is delivered,
  - the next cycle enters FAULT with fault_addr=16384.
- Assert rst_n=0 mid-stream: all outputs clear asynchronously before the next clk edge, and fsm_state=0.
